// File: rtl/bp_nonsynth_cache_profiler.sv
// Banked performance profiler for an L1 cache engine.
//
// Counts tag and per-bank data mem accesses and tracks miss latency
// statistics (count, min, max, total). All counts are per sampling window and
// saturate. At the end of every window the live values are copied into
// snapshot registers, and one of them can be read back through stat_sel_i.
// Miss start/complete and window-end events are timestamped and pushed into a
// small trace FIFO. A valid/yumi consumer drains the FIFO. Events that find the
// FIFO full are counted as dropped.
//
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   freeze_i                suspends counting, timestamp, window and miss FSM
//   tag_mem_v_i             tag mem access this cycle
//   data_mem_v_i            per-bank data mem access this cycle
//   cache_req_v_i/_yumi_i   request handshake; _miss_i marks it as a miss
//   cache_req_complete_i    completion of the outstanding miss
//   stat_sel_i / stat_o     snapshot statistic select / value (combinational)
//   snapshot_v_o            one-cycle pulse after the snapshot is updated
//   trace_v_o/_data_o       FIFO head valid / {type[1:0], timestamp}
//   trace_yumi_i            consumer pops the FIFO head
module bp_nonsynth_cache_profiler #(
    parameter int  num_banks_p       = 8,
    parameter int  counter_width_p   = 32,
    parameter int  timestamp_width_p = 32,
    parameter int  window_cycles_p   = 1024,
    parameter int  trace_depth_p     = 8,
    localparam int num_stats_lp      = num_banks_p + 6,
    localparam int stat_sel_width_lp = $clog2(num_stats_lp),
    localparam int trace_width_lp    = 2 + timestamp_width_p
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         freeze_i,
    input  logic                         tag_mem_v_i,
    input  logic [num_banks_p-1:0]       data_mem_v_i,
    input  logic                         cache_req_v_i,
    input  logic                         cache_req_yumi_i,
    input  logic                         cache_req_miss_i,
    input  logic                         cache_req_complete_i,
    input  logic [stat_sel_width_lp-1:0] stat_sel_i,
    output logic [counter_width_p-1:0]   stat_o,
    output logic                         snapshot_v_o,
    output logic                         trace_v_o,
    output logic [trace_width_lp-1:0]    trace_data_o,
    input  logic                         trace_yumi_i
);

    localparam int win_width_lp = $clog2(window_cycles_p);
    localparam int ptr_width_lp = $clog2(trace_depth_p);
    localparam int cnt_width_lp = ptr_width_lp + 1;
    localparam int wide_lp      = (timestamp_width_p > counter_width_p) ? timestamp_width_p : counter_width_p;

    function automatic logic [counter_width_p-1:0] sat_add(
        input logic [counter_width_p-1:0] a,
        input logic [counter_width_p-1:0] b
    );
        logic [counter_width_p:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[counter_width_p] ? {counter_width_p{1'b1}} : sum[counter_width_p-1:0];
    endfunction

    typedef enum logic {ST_IDLE, ST_PEND} miss_state_e;

    miss_state_e                  state_reg, state_next;
    logic [timestamp_width_p-1:0] ts_reg, start_reg, start_next, latency;
    logic [win_width_lp-1:0]      win_reg;
    logic                         active, win_end, req_accept, miss_start, miss_done;
    logic [wide_lp-1:0]           latency_wide;
    logic [counter_width_p-1:0]   lat_c;

    assign active  = ~freeze_i;
    assign win_end = active && (win_reg == win_width_lp'(window_cycles_p - 1));

    // Free-running timestamp and window position, both paused by freeze.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ts_reg  <= '0;
            win_reg <= '0;
        end else if (active) begin
            ts_reg  <= ts_reg + 1'b1;
            win_reg <= win_end ? '0 : win_reg + 1'b1;
        end
    end

    // ---------------- miss FSM ----------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg <= ST_IDLE;
            start_reg <= '0;
        end else begin
            state_reg <= state_next;
            start_reg <= start_next;
        end
    end

    assign req_accept = cache_req_v_i & cache_req_yumi_i & cache_req_miss_i;

    always_comb begin
        state_next = state_reg;
        start_next = start_reg;
        miss_start = 1'b0;
        miss_done  = 1'b0;
        if (active) begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_accept) begin
                        state_next = ST_PEND;
                        start_next = ts_reg;
                        miss_start = 1'b1;
                    end
                end
                ST_PEND: begin
                    // Accepts while waiting are ignored unless the pending
                    // miss completes in the same cycle, which frees the FSM.
                    if (cache_req_complete_i) begin
                        miss_done  = 1'b1;
                        state_next = ST_IDLE;
                        if (req_accept) begin
                            state_next = ST_PEND;
                            start_next = ts_reg;
                            miss_start = 1'b1;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Modulo subtraction keeps latency correct across timestamp wrap; the
    // result is clamped if the statistic counters are narrower.
    assign latency      = ts_reg - start_reg;
    assign latency_wide = wide_lp'(latency);
    assign lat_c = (latency_wide > wide_lp'({counter_width_p{1'b1}}))
                 ? {counter_width_p{1'b1}} : counter_width_p'(latency_wide);

    // ---------------- trace FIFO ----------------
    logic [trace_width_lp-1:0]      fifo_mem [trace_depth_p];
    logic [ptr_width_lp-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [cnt_width_lp-1:0]        count_reg, count_next, free_slots;
    logic                           pop;
    logic [2:0]                     push_v, push_ok;
    logic [2:0][trace_width_lp-1:0] push_data;
    logic [2:0][ptr_width_lp-1:0]   push_slot;
    logic [1:0]                     n_acc, drop_cnt;

    always_comb begin
        pop          = trace_yumi_i && (count_reg != '0);
        // Index order is push priority: completion, start, window end.
        push_v       = {win_end, miss_start, miss_done};
        push_data[0] = {2'd1, ts_reg};
        push_data[1] = {2'd0, ts_reg};
        push_data[2] = {2'd2, ts_reg};
        free_slots   = cnt_width_lp'(trace_depth_p) - count_reg + cnt_width_lp'(pop);
        n_acc        = '0;
        drop_cnt     = '0;
        push_ok      = '0;
        push_slot    = '0;
        for (int k = 0; k < 3; k++) begin
            if (push_v[k]) begin
                if (cnt_width_lp'(n_acc) < free_slots) begin
                    push_ok[k]   = 1'b1;
                    push_slot[k] = wr_ptr_reg + ptr_width_lp'(n_acc);
                    n_acc        = n_acc + 2'd1;
                end else begin
                    drop_cnt = drop_cnt + 2'd1;
                end
            end
        end
        count_next = count_reg - cnt_width_lp'(pop) + cnt_width_lp'(n_acc);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + ptr_width_lp'(n_acc);
            rd_ptr_reg <= rd_ptr_reg + ptr_width_lp'(pop);
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 3; k++) begin
            if (push_ok[k]) fifo_mem[push_slot[k]] <= push_data[k];
        end
    end

    assign trace_v_o    = (count_reg != '0);
    assign trace_data_o = fifo_mem[rd_ptr_reg];

    // ---------------- live counters ----------------
    // At window end the live values restart from their cleared state and
    // still absorb this cycle's events, so those land in the new window.
    logic [counter_width_p-1:0] tag_reg, miss_reg, min_reg, max_reg, tot_reg, drop_reg;
    logic                       done_any_reg;
    logic [counter_width_p-1:0] min_base, max_base;
    logic [num_banks_p-1:0][counter_width_p-1:0] bank_cnt;

    assign min_base = win_end ? {counter_width_p{1'b1}} : min_reg;
    assign max_base = win_end ? '0 : max_reg;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tag_reg      <= '0;
            miss_reg     <= '0;
            min_reg      <= {counter_width_p{1'b1}};
            max_reg      <= '0;
            tot_reg      <= '0;
            drop_reg     <= '0;
            done_any_reg <= 1'b0;
        end else begin
            tag_reg      <= sat_add(win_end ? '0 : tag_reg, counter_width_p'(tag_mem_v_i & active));
            miss_reg     <= sat_add(win_end ? '0 : miss_reg, counter_width_p'(miss_start));
            min_reg      <= (miss_done && (lat_c < min_base)) ? lat_c : min_base;
            max_reg      <= (miss_done && (lat_c > max_base)) ? lat_c : max_base;
            tot_reg      <= sat_add(win_end ? '0 : tot_reg, miss_done ? lat_c : '0);
            drop_reg     <= sat_add(win_end ? '0 : drop_reg, counter_width_p'(drop_cnt));
            done_any_reg <= (win_end ? 1'b0 : done_any_reg) | miss_done;
        end
    end

    genvar gi;
    for (gi = 0; gi < num_banks_p; gi++) begin : g_bank
        logic [counter_width_p-1:0] cnt_reg;
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) cnt_reg <= '0;
            else            cnt_reg <= sat_add(win_end ? '0 : cnt_reg,
                                               counter_width_p'(data_mem_v_i[gi] & active));
        end
        assign bank_cnt[gi] = cnt_reg;
    end

    // ---------------- snapshots ----------------
    logic [num_stats_lp-1:0][counter_width_p-1:0] live_vec, snap_reg;
    logic                                         snap_v_reg;

    always_comb begin
        live_vec = '0;
        live_vec[0] = tag_reg;
        for (int b = 0; b < num_banks_p; b++) live_vec[1 + b] = bank_cnt[b];
        live_vec[num_banks_p + 1] = miss_reg;
        // The all-ones min sentinel is never published.
        live_vec[num_banks_p + 2] = done_any_reg ? min_reg : '0;
        live_vec[num_banks_p + 3] = max_reg;
        live_vec[num_banks_p + 4] = tot_reg;
        live_vec[num_banks_p + 5] = drop_reg;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            snap_reg   <= '0;
            snap_v_reg <= 1'b0;
        end else begin
            if (win_end) snap_reg <= live_vec;
            snap_v_reg <= win_end;
        end
    end

    assign snapshot_v_o = snap_v_reg;

    always_comb begin
        stat_o = '0;
        for (int s = 0; s < num_stats_lp; s++) begin
            if (stat_sel_i == stat_sel_width_lp'(s)) stat_o = snap_reg[s];
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_cache_profiler.sv
module tb_bp_nonsynth_cache_profiler;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        freeze = 1'b0;
    logic        tag_v = 1'b0;
    logic [7:0]  data_v = '0;
    logic        req_v = 1'b0, req_yumi = 1'b0, req_miss = 1'b0, complete = 1'b0;
    logic [3:0]  stat_sel = '0;
    logic [31:0] stat;
    logic        snap_v, trace_v;
    logic [33:0] trace_data;
    logic        trace_yumi = 1'b0;

    logic [2:0]  sat_stat_sel = '0;
    logic [3:0]  sat_stat;
    logic        sat_snap_v, sat_trace_v;
    logic [9:0]  sat_trace_data;

    int ts_model;
    int total_checks = 0;
    int pass_checks  = 0;

    always #5 clk = ~clk;

    bp_nonsynth_cache_profiler dut (
        .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze),
        .tag_mem_v_i(tag_v), .data_mem_v_i(data_v),
        .cache_req_v_i(req_v), .cache_req_yumi_i(req_yumi), .cache_req_miss_i(req_miss),
        .cache_req_complete_i(complete),
        .stat_sel_i(stat_sel), .stat_o(stat), .snapshot_v_o(snap_v),
        .trace_v_o(trace_v), .trace_data_o(trace_data), .trace_yumi_i(trace_yumi)
    );

    // Narrow instance: 4-bit counters, 8-bit timestamp, 32-cycle window.
    bp_nonsynth_cache_profiler #(
        .num_banks_p(2), .counter_width_p(4), .timestamp_width_p(8),
        .window_cycles_p(32), .trace_depth_p(4)
    ) dut_sat (
        .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze),
        .tag_mem_v_i(tag_v), .data_mem_v_i(data_v[1:0]),
        .cache_req_v_i(req_v), .cache_req_yumi_i(req_yumi), .cache_req_miss_i(req_miss),
        .cache_req_complete_i(complete),
        .stat_sel_i(sat_stat_sel), .stat_o(sat_stat), .snapshot_v_o(sat_snap_v),
        .trace_v_o(sat_trace_v), .trace_data_o(sat_trace_data), .trace_yumi_i(1'b1)
    );

    // Expected timestamp: number of unfrozen edges since reset release.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)     ts_model <= 0;
        else if (!freeze) ts_model <= ts_model + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        assert (obs === exp) pass_checks++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic go_to(input int t);
        int guard = 0;
        while (ts_model != t && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (ts_model != t) begin
            total_checks++;
            $error("FAIL go_to: observed ts=%0d expected ts=%0d", ts_model, t);
        end
    endtask

    task automatic accept_pulse();
        req_v = 1'b1; req_yumi = 1'b1; req_miss = 1'b1;
        @(negedge clk);
        req_v = 1'b0; req_yumi = 1'b0; req_miss = 1'b0;
    endtask

    task automatic complete_pulse();
        complete = 1'b1;
        @(negedge clk);
        complete = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [1:0] ty, input logic [31:0] t);
        logic [33:0] e;
        e = {ty, t};
        chk({tag, "_v"}, 64'(trace_v), 64'd1);
        chk(tag, 64'(trace_data), 64'(e));
        $display("trace pop %s: type=%0d ts=%0d", tag, trace_data[33:32], trace_data[31:0]);
        trace_yumi = 1'b1;
        @(negedge clk);
        trace_yumi = 1'b0;
    endtask

    task automatic read_stat(input string tag, input int sel, input logic [31:0] exp);
        stat_sel = 4'(sel);
        #1;
        chk(tag, 64'(stat), 64'(exp));
        $display("stat %s sel=%0d value=%0d", tag, sel, stat);
    endtask

    task automatic read_sat(input string tag, input int sel, input logic [3:0] exp);
        sat_stat_sel = 3'(sel);
        #1;
        chk(tag, 64'(sat_stat), 64'(exp));
        $display("sat stat %s sel=%0d value=%0d", tag, sel, sat_stat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_snap_v", 64'(snap_v), 64'd0);
        chk("rst_trace_v", 64'(trace_v), 64'd0);
        read_stat("rst_stat_tag", 0, 32'd0);
        read_stat("rst_stat_min", 10, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- window 0: idle ----
        go_to(1023);
        chk("w0_snap_v_early", 64'(snap_v), 64'd0);
        @(negedge clk);
        chk("w0_snap_v", 64'(snap_v), 64'd1);
        pop_check("w0_end", 2'd2, 32'd1023);
        chk("w0_snap_v_off", 64'(snap_v), 64'd0);
        chk("w0_empty", 64'(trace_v), 64'd0);
        for (int s = 0; s < 16; s++) read_stat("w0_stat", s, 32'd0);

        // ---- window 1: accesses, misses, freeze ----
        go_to(1030); tag_v = 1'b1; data_v[3] = 1'b1; data_v[7] = 1'b1;
        go_to(1032); data_v[7] = 1'b0;
        go_to(1034); accept_pulse();
        go_to(1037); data_v[3] = 1'b0;
        go_to(1050); tag_v = 1'b0;
        go_to(1059); complete_pulse();
        chk("sat_tag_saturated", 64'(sat_stat), 64'd15);
        pop_check("m1_start", 2'd0, 32'd1034);
        pop_check("m1_done", 2'd1, 32'd1059);
        chk("m1_empty", 64'(trace_v), 64'd0);
        go_to(1090);
        chk("sat_tag_next_window", 64'(sat_stat), 64'd0);
        go_to(1100); complete_pulse();
        chk("idle_complete_ignored", 64'(trace_v), 64'd0);
        trace_yumi = 1'b1;
        go_to(1200); accept_pulse();
        go_to(1202); accept_pulse();
        go_to(1240); complete_pulse();
        go_to(1300); accept_pulse();
        go_to(1305); complete = 1'b1; accept_pulse(); complete = 1'b0;
        go_to(1312); complete_pulse();
        go_to(1400); freeze = 1'b1; tag_v = 1'b1;
        repeat (3) @(negedge clk);
        freeze = 1'b0; tag_v = 1'b0;
        go_to(2040); trace_yumi = 1'b0;
        go_to(2048);
        chk("w1_snap_v", 64'(snap_v), 64'd1);
        pop_check("w1_end", 2'd2, 32'd2047);
        chk("w1_snap_v_off", 64'(snap_v), 64'd0);
        read_stat("w1_tag", 0, 32'd20);
        read_stat("w1_bank0", 1, 32'd0);
        read_stat("w1_bank3", 4, 32'd7);
        read_stat("w1_bank7", 8, 32'd2);
        read_stat("w1_miss", 9, 32'd4);
        read_stat("w1_min", 10, 32'd5);
        read_stat("w1_max", 11, 32'd40);
        read_stat("w1_total", 12, 32'd77);
        read_stat("w1_drop", 13, 32'd0);
        read_stat("w1_out_of_range", 14, 32'd0);

        // ---- window 2: stalled consumer, FIFO overflow ----
        for (int k = 0; k < 6; k++) begin
            go_to(2100 + 10 * k); accept_pulse();
            go_to(2102 + 10 * k); complete_pulse();
        end
        go_to(3072);
        chk("w2_snap_v", 64'(snap_v), 64'd1);
        pop_check("w2_head", 2'd0, 32'd2100);
        read_stat("w2_miss", 9, 32'd6);
        read_stat("w2_min", 10, 32'd2);
        read_stat("w2_total", 12, 32'd12);
        read_stat("w2_drop", 13, 32'd4);
        go_to(3100); accept_pulse();
        pop_check("w2_e1", 2'd1, 32'd2102);
        pop_check("w2_e2", 2'd0, 32'd2110);
        pop_check("w2_e3", 2'd1, 32'd2112);
        pop_check("w2_e4", 2'd0, 32'd2120);
        pop_check("w2_e5", 2'd1, 32'd2122);
        pop_check("w2_e6", 2'd0, 32'd2130);
        pop_check("w2_e7", 2'd1, 32'd2132);
        pop_check("w2_after_pop", 2'd0, 32'd3100);
        chk("w2_drained", 64'(trace_v), 64'd0);

        // ---- window 3: narrow-timestamp wrap on the small instance ----
        go_to(3110); complete_pulse(); trace_yumi = 1'b1;
        go_to(3325); accept_pulse();
        go_to(3330); complete_pulse();
        go_to(3365);
        read_sat("sat_wrap_min", 4, 4'd5);
        read_sat("sat_wrap_max", 5, 4'd5);
        read_sat("sat_wrap_total", 6, 4'd5);
        read_sat("sat_wrap_miss", 3, 4'd0);
        go_to(4096);
        read_stat("w3_miss", 9, 32'd2);
        read_stat("w3_min", 10, 32'd5);
        read_stat("w3_max", 11, 32'd10);
        read_stat("w3_total", 12, 32'd15);
        read_stat("w3_drop", 13, 32'd1);

        // ---- reset in the middle of a pending miss ----
        go_to(4150); trace_yumi = 1'b0;
        go_to(4200); accept_pulse();
        go_to(4205);
        chk("pre_reset_trace_v", 64'(trace_v), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_trace_v", 64'(trace_v), 64'd0);
        read_stat("async_reset_miss", 9, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        go_to(5); complete_pulse();
        chk("post_reset_idle", 64'(trace_v), 64'd0);
        go_to(10); accept_pulse();
        pop_check("r_start", 2'd0, 32'd10);
        go_to(35); complete_pulse();
        pop_check("r_done", 2'd1, 32'd35);
        chk("r_empty", 64'(trace_v), 64'd0);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
